// File: rtl/mem_bus_arbiter_if.sv
// ============================================================================
// mem_bus_arbiter_if : external memory bus between the arbiter and memory
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_bus_arbiter_if;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;

    modport master (
        output bus_req, bus_we, bus_sel, bus_addr, bus_wdata, bus_err,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_sel, bus_addr, bus_wdata, bus_err,
        output bus_rdata, bus_ack
    );
endinterface

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// mem_bus_arbiter : serialises fetch and data ports onto one memory bus,
//                   data first, with per-port stalls and a bus timeout
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_ce_i,
    input  logic [31:0]        if_addr_i,
    output logic [31:0]        if_data_o,
    output logic               if_stall_o,
    input  logic               d_ce_i,
    input  logic               d_we_i,
    input  logic [3:0]         d_sel_i,
    input  logic [31:0]        d_addr_i,
    input  logic [31:0]        d_wdata_i,
    output logic [31:0]        d_rdata_o,
    output logic               d_stall_o,
    mem_bus_arbiter_if.master  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_INST = 2'd2;

    localparam logic [9:0] C_TMO_LAST = 10'(TIMEOUT - 1);

    logic [1:0]  state_q,   state_d;
    logic        i_done_q,  i_done_d;
    logic        d_done_q,  d_done_d;
    logic        req_q,     req_d;
    logic        we_q,      we_d;
    logic [3:0]  sel_q,     sel_d;
    logic [31:0] addr_q,    addr_d;
    logic [31:0] wdata_q,   wdata_d;
    logic        err_q,     err_d;
    logic [9:0]  cnt_q,     cnt_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic w_if_stall;
    logic w_d_stall;
    logic w_advance;
    logic w_is_data;
    logic w_port_ce;

    assign w_if_stall = if_ce_i & ~i_done_q;
    assign w_d_stall  = d_ce_i  & ~d_done_q;
    assign w_advance  = ~w_if_stall & ~w_d_stall;
    assign w_is_data  = (state_q == S_DATA);
    assign w_port_ce  = w_is_data ? d_ce_i : if_ce_i;

    // Stalls are gated by reset so the pipeline is never frozen while held in reset
    assign if_stall_o = rst & w_if_stall;
    assign d_stall_o  = rst & w_d_stall;

    assign if_data_o     = if_data_q;
    assign d_rdata_o     = d_rdata_q;
    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_sel   = sel_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_err   = err_q;

    always_comb begin
        state_d   = state_q;
        i_done_d  = i_done_q;
        d_done_d  = d_done_q;
        req_d     = req_q;
        we_d      = we_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        if_data_d = if_data_q;
        d_rdata_d = d_rdata_q;

        if (w_advance) begin
            i_done_d = 1'b0;
            d_done_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                // Data wins a tie: the MEM-stage instruction is the older one
                if (d_ce_i && !d_done_q) begin
                    state_d = S_DATA;
                    req_d   = 1'b1;
                    we_d    = d_we_i;
                    sel_d   = d_sel_i;
                    addr_d  = d_addr_i;
                    wdata_d = d_we_i ? d_wdata_i : 32'h0;
                    cnt_d   = 10'd0;
                end else if (if_ce_i && !i_done_q) begin
                    state_d = S_INST;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    sel_d   = 4'hF;
                    addr_d  = if_addr_i;
                    wdata_d = 32'h0;
                    cnt_d   = 10'd0;
                end
            end

            S_DATA, S_INST: begin
                if (bus.bus_ack || (cnt_q == C_TMO_LAST)) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    cnt_d   = 10'd0;
                    if (!bus.bus_ack) begin
                        err_d = 1'b1;
                    end
                    // A flushed port (ce dropped) neither completes nor updates its register
                    if (w_port_ce) begin
                        if (w_is_data) begin
                            d_done_d  = 1'b1;
                            d_rdata_d = (bus.bus_ack && !we_q) ? bus.bus_rdata : 32'h0;
                        end else begin
                            i_done_d  = 1'b1;
                            if_data_d = bus.bus_ack ? bus.bus_rdata : 32'h0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= 4'h0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            err_q     <= 1'b0;
            cnt_q     <= 10'd0;
            if_data_q <= 32'h0;
            d_rdata_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
            req_q     <= req_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            if_data_q <= if_data_d;
            d_rdata_q <= d_rdata_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// tb_mem_bus_arbiter : scoreboard bench with a memory-level reference model
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;

    localparam int unsigned TMO = 8;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        bit          noack;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_ce = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic [31:0] if_data;
    logic        if_stall;
    logic        d_ce = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_sel = 4'h0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic [31:0] d_rdata;
    logic        d_stall;

    mem_bus_arbiter_if bus_if ();

    mem_bus_arbiter #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_ce_i    (if_ce),
        .if_addr_i  (if_addr),
        .if_data_o  (if_data),
        .if_stall_o (if_stall),
        .d_ce_i     (d_ce),
        .d_we_i     (d_we),
        .d_sel_i    (d_sel),
        .d_addr_i   (d_addr),
        .d_wdata_i  (d_wdata),
        .d_rdata_o  (d_rdata),
        .d_stall_o  (d_stall),
        .bus        (bus_if.master)
    );

    always #5 clk = ~clk;

    txn_t        txq[$];
    logic [31:0] exp_if_q[$];
    logic [31:0] exp_d_q[$];
    logic [31:0] ref_mem [logic [29:0]];
    logic [31:0] bus_mem [logic [29:0]];
    bit          exp_err = 1'b0;
    logic [31:0] last_if_exp = 32'h0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : init_val(a);
    endfunction

    function automatic logic [31:0] bus_rd(input logic [31:0] a);
        return bus_mem.exists(a[31:2]) ? bus_mem[a[31:2]] : init_val(a);
    endfunction

    // Memory slave: pops one descriptor per access and answers after its wait count
    txn_t s_t;
    bit   s_act = 1'b0;
    int   s_cyc = 0;

    always @(negedge clk) begin
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = $urandom;
        if (!rst) begin
            s_act = 1'b0;
        end else begin
            if (s_act && !bus_if.bus_req) begin
                check("timeout_len", 64'(s_cyc), 64'(TMO));
                s_act = 1'b0;
            end
            if (!s_act && bus_if.bus_req) begin
                if (txq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_bus_access: addr %0h with no access expected", bus_if.bus_addr);
                end else begin
                    s_t   = txq.pop_front();
                    s_act = 1'b1;
                    s_cyc = 0;
                end
            end
            if (s_act) begin
                s_cyc++;
                check("bus_addr", 64'(bus_if.bus_addr), 64'(s_t.addr));
                check("bus_we_sel_wdata", 64'({bus_if.bus_we, bus_if.bus_sel, bus_if.bus_wdata}),
                      64'({s_t.we, s_t.sel, s_t.wdata}));
                if (!s_t.noack && s_cyc > s_t.waits) begin
                    bus_if.bus_ack = 1'b1;
                    if (s_t.we)
                        bus_mem[s_t.addr[31:2]] = merge(bus_rd(s_t.addr), s_t.wdata, s_t.sel);
                    else
                        bus_if.bus_rdata = bus_rd(s_t.addr);
                    s_act = 1'b0;
                end
            end
        end
    end

    // Monitor: at each advance cycle the requesting ports hand their words to the pipeline
    always @(negedge clk) begin
        if (rst && !if_stall && !d_stall) begin
            if (if_ce) begin
                if (exp_if_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL if_scoreboard: got %0h, no fetch expected", if_data);
                end else check("if_data", 64'(if_data), 64'(exp_if_q.pop_front()));
            end
            if (d_ce) begin
                if (exp_d_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL d_scoreboard: got %0h, no data access expected", d_rdata);
                end else check("d_rdata", 64'(d_rdata), 64'(exp_d_q.pop_front()));
            end
            if (if_ce || d_ce) check("bus_err", 64'(bus_if.bus_err), 64'(exp_err));
        end
    end

    task automatic prep(input bit di, input logic [31:0] ia, input int iw, input bit inoack,
                        input bit dd, input bit we, input logic [3:0] sel, input logic [31:0] da,
                        input logic [31:0] wd, input int dw, input bit dnoack);
        logic [31:0] e;
        if (dd) begin
            txq.push_back('{we, sel, da, (we ? wd : 32'h0), dw, dnoack});
            if (dnoack) begin
                e = 32'h0;
                exp_err = 1'b1;
            end else if (we) begin
                e = 32'h0;
                ref_mem[da[31:2]] = merge(ref_rd(da), wd, sel);
            end else begin
                e = ref_rd(da);
            end
            exp_d_q.push_back(e);
        end
        if (di) begin
            txq.push_back('{1'b0, 4'hF, ia, 32'h0, iw, inoack});
            if (inoack) begin
                e = 32'h0;
                exp_err = 1'b1;
            end else begin
                e = ref_rd(ia);
            end
            exp_if_q.push_back(e);
            last_if_exp = e;
        end
    endtask

    task automatic finish_step(input bit di, input bit dd, output int ic, output int dc);
        bit adv;
        ic = 0;
        dc = 0;
        adv = 1'b0;
        @(negedge clk);
        if (di) check("if_stall_start", 64'(if_stall), 64'd1);
        if (dd) check("d_stall_start", 64'(d_stall), 64'd1);
        for (int k = 0; k < 300; k++) begin
            if (!if_stall && !d_stall) begin
                adv = 1'b1;
                break;
            end
            if (if_stall) ic++;
            if (d_stall) dc++;
            @(negedge clk);
        end
        if (!adv) begin
            n_cmp++; n_bad++;
            $display("FAIL advance_timeout: stalls if=%0b d=%0b never released", if_stall, d_stall);
        end
        @(posedge clk);
        #1;
        if_ce = 1'b0;
        d_ce  = 1'b0;
    endtask

    task automatic run_step(input bit di, input logic [31:0] ia, input int iw, input bit inoack,
                            input bit dd, input bit we, input logic [3:0] sel, input logic [31:0] da,
                            input logic [31:0] wd, input int dw, input bit dnoack,
                            output int ic, output int dc);
        prep(di, ia, iw, inoack, dd, we, sel, da, wd, dw, dnoack);
        if_ce = di; if_addr = ia;
        d_ce = dd; d_we = we; d_sel = sel; d_addr = da; d_wdata = wd;
        finish_step(di, dd, ic, dc);
    endtask

    task automatic wait_bus_req(input logic lvl);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus_if.bus_req === lvl) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL bus_req_wait: bus_req never reached %0b", lvl);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    int          ic, dc;
    bit          r_di, r_dd, r_we, r_in, r_dn;
    logic [31:0] r_ia, r_da, r_wd;
    logic [3:0]  r_sel;
    int          r_iw, r_dw;

    initial begin
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 32'h0;

        // Reset state, with both ports requesting to show the stalls are forced low
        if_ce = 1'b1; d_ce = 1'b1;
        #12;
        check("rst_stalls", 64'({if_stall, d_stall}), 64'd0);
        check("rst_bus_ctl", 64'({bus_if.bus_req, bus_if.bus_we, bus_if.bus_sel, bus_if.bus_err}), 64'd0);
        check("rst_bus_addr", 64'(bus_if.bus_addr), 64'd0);
        check("rst_bus_wdata", 64'(bus_if.bus_wdata), 64'd0);
        check("rst_holding", 64'({if_data, d_rdata}), 64'd0);
        if_ce = 1'b0; d_ce = 1'b0;
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #1;

        // Lone fetch, zero-wait
        bus_mem[30'h40] = 32'h3C011234;
        ref_mem[30'h40] = 32'h3C011234;
        run_step(1'b1, 32'h100, 0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 0, 1'b0, ic, dc);
        check("lone_fetch_stall_cycles", 64'(ic), 64'd2);

        // Simultaneous load and fetch: data goes first
        run_step(1'b1, 32'h104, 0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h2000, 32'h0, 0, 1'b0, ic, dc);
        check("dual_d_stall_cycles", 64'(dc), 64'd2);
        check("dual_if_stall_cycles", 64'(ic), 64'd4);

        // Store with 3 wait states
        run_step(1'b0, 32'h0, 0, 1'b0, 1'b1, 1'b1, 4'b0011, 32'h2004, 32'hAABBCCDD, 3, 1'b0, ic, dc);
        check("store_stall_cycles", 64'(dc), 64'd5);
        run_step(1'b0, 32'h0, 0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h2004, 32'h0, 0, 1'b0, ic, dc);

        // Fetch flushed before its ack: no completion, holding register untouched
        txq.push_back('{1'b0, 4'hF, 32'h300, 32'h0, 4, 1'b0});
        if_ce = 1'b1; if_addr = 32'h300;
        wait_bus_req(1'b1);
        @(posedge clk); #1 if_ce = 1'b0;
        wait_bus_req(1'b0);
        @(negedge clk);
        check("flush_if_data_kept", 64'(if_data), 64'(last_if_exp));
        @(posedge clk); #1;
        run_step(1'b1, 32'h200, 1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 0, 1'b0, ic, dc);

        // Reset during a data access; both held requests reissue afterwards
        exp_d_q.push_back(ref_rd(32'h40));
        exp_if_q.push_back(ref_rd(32'h44));
        txq.push_back('{1'b0, 4'hF, 32'h40, 32'h0, 6, 1'b0});
        d_ce = 1'b1; d_we = 1'b0; d_sel = 4'hF; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
        if_ce = 1'b1; if_addr = 32'h44;
        wait_bus_req(1'b1);
        @(posedge clk); #1 rst = 1'b0;
        #1;
        check("midrst_bus_req", 64'(bus_if.bus_req), 64'd0);
        check("midrst_stalls", 64'({if_stall, d_stall}), 64'd0);
        txq.push_back('{1'b0, 4'hF, 32'h40, 32'h0, 1, 1'b0});
        txq.push_back('{1'b0, 4'hF, 32'h44, 32'h0, 0, 1'b0});
        @(posedge clk); #2 rst = 1'b1;
        finish_step(1'b1, 1'b1, ic, dc);

        // Bus timeout on a load
        run_step(1'b0, 32'h0, 0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h2008, 32'h0, 0, 1'b1, ic, dc);
        check("timeout_stall_cycles", 64'(dc), 64'(TMO + 1));
        check("timeout_err_sticky", 64'(bus_if.bus_err), 64'd1);

        // Randomised traffic over a small shared address window
        for (int s = 0; s < 150; s++) begin
            r_di  = 1'($urandom_range(0, 1));
            r_dd  = 1'($urandom_range(0, 1));
            if (!r_di && !r_dd) r_di = 1'b1;
            r_ia  = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
            r_da  = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
            r_we  = 1'($urandom_range(0, 1));
            r_sel = 4'($urandom_range(1, 15));
            r_wd  = $urandom;
            r_iw  = int'($urandom_range(0, 4));
            r_dw  = int'($urandom_range(0, 4));
            r_in  = ($urandom_range(0, 24) == 0);
            r_dn  = ($urandom_range(0, 24) == 0);
            run_step(r_di, r_ia, r_iw, r_in, r_dd, r_we, r_sel, r_da, r_wd, r_dw, r_dn, ic, dc);
        end

        repeat (5) @(negedge clk);
        check("leftover_bus_txns", 64'(txq.size()), 64'd0);
        check("leftover_if_expect", 64'(exp_if_q.size()), 64'd0);
        check("leftover_d_expect", 64'(exp_d_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
